// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect input and the
// {instr, pc} valid/ready handshake towards decode.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_target,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    output fetch_halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_target,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    input  fetch_halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational instruction
// memory and buffers {pc, word} in a small in-order queue for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_BYTES = 36
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int             PW         = $clog2(DEPTH);
  localparam logic [PW:0]    DEPTH_CNT  = (PW+1)'(DEPTH);
  localparam logic [PW:0]    CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
  localparam logic [32:0]    IMEM_LIMIT = 33'(IMEM_BYTES);

  logic [31:0]   pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];

  logic halted;
  logic valid;
  logic push;
  logic pop;

  // A full queue may still accept a word when decode drains the head this cycle.
  always_comb begin
    halted = ({1'b0, pc} + 33'd4) > IMEM_LIMIT;
    valid  = (count != '0);
    pop    = valid && bus.instr_ready;
    push   = !reset && !bus.redirect_valid && !halted && ((count < DEPTH_CNT) || pop);
  end

  assign bus.imem_addr    = pc;
  assign bus.fetch_halted = halted;
  assign bus.instr_valid  = valid;
  assign bus.instr        = valid ? q_instr[rd_ptr] : 32'h0;
  assign bus.instr_pc     = valid ? q_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect_valid) begin
      // A same-cycle pop is already accepted by decode; the flush discards the rest.
      pc     <= {bus.redirect_target[31:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.imem_data;
      q_pc[wr_ptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: two instances (28- and 36-byte memories)
// share a memory model; handshakes are scored against a queue of expected PCs.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] sb_a [$];
  logic [31:0] sb_b [$];

  fetch_unit_if bus_a ();
  fetch_unit_if bus_b ();

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2), .IMEM_BYTES(28)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.master)
  );

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(2), .IMEM_BYTES(36)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  mem_word = 32'h0001_1020;
      32'h04:  mem_word = 32'h0085_3022;
      32'h08:  mem_word = 32'h0109_5024;
      32'h0C:  mem_word = 32'h0128_5025;
      32'h10:  mem_word = 32'h0166_0180;
      32'h14:  mem_word = 32'h01A9_0282;
      32'h18:  mem_word = 32'hFC20_0008;
      32'h1C:  mem_word = 32'h0000_0013;
      32'h20:  mem_word = 32'h0040_0093;
      default: mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus_a.imem_data = mem_word(bus_a.imem_addr);
  assign bus_b.imem_data = mem_word(bus_b.imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit sel_b, input logic rst, input logic rv,
                               input logic [31:0] tgt, input logic rdy);
    if (sel_b) begin
      reset_b               = rst;
      bus_b.redirect_valid  = rv;
      bus_b.redirect_target = tgt;
      bus_b.instr_ready     = rdy;
    end else begin
      reset_a               = rst;
      bus_a.redirect_valid  = rv;
      bus_a.redirect_target = tgt;
      bus_a.instr_ready     = rdy;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every accepted instruction must match the oldest outstanding expected PC.
  always @(negedge clk) begin
    if (!reset_a && bus_a.instr_valid && bus_a.instr_ready) begin
      if (sb_a.size() == 0) begin
        checkOutput("a_unexpected_pop", bus_a.instr_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb_a.pop_front();
        checkOutput("a_pc", bus_a.instr_pc, exp_pc);
        checkOutput("a_word", bus_a.instr, mem_word(exp_pc));
      end
    end
    if (!reset_b && bus_b.instr_valid && bus_b.instr_ready) begin
      if (sb_b.size() == 0) begin
        checkOutput("b_unexpected_pop", bus_b.instr_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb_b.pop_front();
        checkOutput("b_pc", bus_b.instr_pc, exp_pc);
        checkOutput("b_word", bus_b.instr, mem_word(exp_pc));
      end
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

    // Streaming with decode always ready
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_valid", bus_a.instr_valid, 32'd0);
    checkOutput("rst_instr", bus_a.instr, 32'd0);
    checkOutput("rst_pc", bus_a.instr_pc, 32'd0);
    checkOutput("rst_halted", bus_a.fetch_halted, 32'd0);
    checkOutput("rst_addr", bus_a.imem_addr, 32'd0);
    for (int i = 0; i < 7; i++) sb_a.push_back(32'(4 * i));
    for (int c = 1; c <= 7; c++) begin
      tick();
      checkOutput("stream_valid", bus_a.instr_valid, 32'd1);
    end
    checkOutput("stream_halted", bus_a.fetch_halted, 32'd1);
    tick();
    checkOutput("stream_end_valid", bus_a.instr_valid, 32'd0);
    checkOutput("stream_end_instr", bus_a.instr, 32'd0);
    checkOutput("stream_sb_left", 32'(sb_a.size()), 32'd0);

    // Back-pressure from reset, then release
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) sb_a.push_back(32'(4 * i));
    tick();
    tick();
    for (int c = 2; c <= 3; c++) begin
      checkOutput("bp_valid", bus_a.instr_valid, 32'd1);
      checkOutput("bp_head_pc", bus_a.instr_pc, 32'h0);
      checkOutput("bp_head_word", bus_a.instr, 32'h0001_1020);
      checkOutput("bp_pc_hold", bus_a.imem_addr, 32'h8);
      if (c == 2) tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkOutput("full_pop_valid", bus_a.instr_valid, 32'd1);
    checkOutput("full_pop_pc", bus_a.instr_pc, 32'h4);
    checkOutput("full_pop_word", bus_a.instr, 32'h0085_3022);
    checkOutput("full_pop_addr", bus_a.imem_addr, 32'hC);
    for (int c = 0; c < 6; c++) tick();
    checkOutput("bp_end_valid", bus_a.instr_valid, 32'd0);
    checkOutput("bp_sb_left", 32'(sb_a.size()), 32'd0);

    // Misaligned redirect during streaming
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    sb_a.push_back(32'h0);
    sb_a.push_back(32'h4);
    sb_a.push_back(32'h10);
    sb_a.push_back(32'h14);
    sb_a.push_back(32'h18);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0011, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_bubble", bus_a.instr_valid, 32'd0);
    checkOutput("redir_addr", bus_a.imem_addr, 32'h10);
    tick();
    checkOutput("redir_valid", bus_a.instr_valid, 32'd1);
    checkOutput("redir_pc", bus_a.instr_pc, 32'h10);
    checkOutput("redir_word", bus_a.instr, 32'h0166_0180);
    for (int c = 0; c < 3; c++) tick();
    checkOutput("redir_end_valid", bus_a.instr_valid, 32'd0);
    checkOutput("redir_sb_left", 32'(sb_a.size()), 32'd0);

    // Reset and redirect together
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0011, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("rr_addr", bus_a.imem_addr, 32'h0);
    checkOutput("rr_valid", bus_a.instr_valid, 32'd0);
    tick();
    checkOutput("rr_head_pc", bus_a.instr_pc, 32'h0);
    checkOutput("rr_head_valid", bus_a.instr_valid, 32'd1);
    checkOutput("rr_next_addr", bus_a.imem_addr, 32'h4);

    // Halt at the end of a 36-byte memory, then recover by redirect
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 1'b1);
    sb_b.push_back(32'h20);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("h_addr_20", bus_b.imem_addr, 32'h20);
    checkOutput("h_not_halted", bus_b.fetch_halted, 32'd0);
    tick();
    checkOutput("h_valid_20", bus_b.instr_valid, 32'd1);
    checkOutput("h_pc_20", bus_b.instr_pc, 32'h20);
    checkOutput("h_addr_24", bus_b.imem_addr, 32'h24);
    checkOutput("h_halted", bus_b.fetch_halted, 32'd1);
    tick();
    checkOutput("h_drained", bus_b.instr_valid, 32'd0);
    checkOutput("h_pc_hold", bus_b.imem_addr, 32'h24);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h4, 1'b1);
    for (int i = 1; i <= 8; i++) sb_b.push_back(32'(4 * i));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("h_unhalted", bus_b.fetch_halted, 32'd0);
    checkOutput("h_addr_4", bus_b.imem_addr, 32'h4);
    checkOutput("h_bubble", bus_b.instr_valid, 32'd0);
    tick();
    checkOutput("h_pc_4", bus_b.instr_pc, 32'h4);
    checkOutput("h_word_4", bus_b.instr, 32'h0085_3022);
    for (int c = 0; c < 8; c++) tick();
    checkOutput("h_end_valid", bus_b.instr_valid, 32'd0);
    checkOutput("h_sb_left", 32'(sb_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
